// File: rtl/dispenser_ctrl.sv
// Portion dispenser controller: synchronizes and debounces the drop sensor, then counts
// portions while the motor runs. Faults when no portion arrives within the timeout window.
module dispenser_ctrl #(
  parameter logic [31:0] CLOCK_FREQ      = 32'd50_000_000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [7:0]  TIMEOUT_SEC     = 8'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_m_on,
  input  logic [2:0] porciones,
  input  logic       sensor_in,
  input  logic       i_clear,
  output logic       motor_on,
  output logic       sensor_on,
  output logic [2:0] o_count,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fault
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

  state_t      state;
  logic        s1, s2, filt, filt_d;
  logic [15:0] deb_cnt;
  logic        m_on_q;
  logic [2:0]  target;
  logic [31:0] tick_cnt;
  logic [7:0]  sec_cnt;
  logic        ev, req_edge;
  logic [3:0]  cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1     <= sensor_in;
      s2     <= s1;
      filt_d <= filt;
      if (s2 == filt)
        deb_cnt <= '0;
      else if (deb_cnt >= DEBOUNCE_CYCLES - 16'd1) begin
        filt    <= s2;
        deb_cnt <= '0;
      end else
        deb_cnt <= deb_cnt + 16'd1;
    end
  end

  assign ev       = filt & ~filt_d;
  assign req_edge = i_m_on & ~m_on_q;
  assign cnt_nxt  = {1'b0, o_count} + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      // Starts high so a request already asserted at reset release is not seen as an edge.
      m_on_q    <= 1'b1;
      target    <= '0;
      o_count   <= '0;
      tick_cnt  <= '0;
      sec_cnt   <= '0;
      motor_on  <= 1'b0;
      o_busy    <= 1'b0;
      sensor_on <= 1'b0;
      o_done    <= 1'b0;
      o_fault   <= 1'b0;
    end else begin
      m_on_q    <= i_m_on;
      sensor_on <= 1'b0;
      o_done    <= 1'b0;
      case (state)
        IDLE: if (req_edge && porciones != 3'd0) begin
          state    <= RUN;
          target   <= porciones;
          o_count  <= '0;
          tick_cnt <= '0;
          sec_cnt  <= '0;
          motor_on <= 1'b1;
          o_busy   <= 1'b1;
        end
        RUN: begin
          if (!i_m_on) begin
            state    <= IDLE;
            motor_on <= 1'b0;
            o_busy   <= 1'b0;
          end else if (ev) begin
            // A portion event outranks a coincident timeout.
            sensor_on <= 1'b1;
            tick_cnt  <= '0;
            sec_cnt   <= '0;
            if (o_count != 3'd7) o_count <= cnt_nxt[2:0];
            if (cnt_nxt == {1'b0, target}) begin
              state    <= DONE;
              motor_on <= 1'b0;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
            end
          end else if (sec_cnt >= TIMEOUT_SEC) begin
            state    <= FAULT;
            motor_on <= 1'b0;
            o_busy   <= 1'b0;
            o_fault  <= 1'b1;
          end else if (tick_cnt >= CLOCK_FREQ - 32'd1) begin
            tick_cnt <= '0;
            sec_cnt  <= sec_cnt + 8'd1;
          end else
            tick_cnt <= tick_cnt + 32'd1;
        end
        DONE: state <= IDLE;
        FAULT: if (i_clear) begin
          state   <= IDLE;
          o_fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dispenser_ctrl.sv
// Bench for dispenser_ctrl: table of dispense scenarios checked through a scoreboard queue,
// plus hand sequences for glitch rejection, fault recovery and asynchronous reset.
module tb_dispenser_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_m_on = 1'b0;
  logic [2:0] porciones = 3'd0;
  logic       sensor_in = 1'b0;
  logic       i_clear = 1'b0;
  logic       motor_on, sensor_on, o_busy, o_done, o_fault;
  logic [2:0] o_count;

  dispenser_ctrl #(.CLOCK_FREQ(32'd20), .DEBOUNCE_CYCLES(16'd4), .TIMEOUT_SEC(8'd3)) dut (
    .clk(clk), .rst_n(rst_n), .i_m_on(i_m_on), .porciones(porciones),
    .sensor_in(sensor_in), .i_clear(i_clear), .motor_on(motor_on),
    .sensor_on(sensor_on), .o_count(o_count), .o_busy(o_busy),
    .o_done(o_done), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] porc;
    int         npulse, hi, lo;
    logic       abort;
    int         tail;
    int         exp_count, exp_sens, exp_done, exp_fault;
  } vec_t;

  vec_t vecs[6];
  vec_t exp_q[$];
  int   vec_cnt = 0, miss_cnt = 0;
  int   sens_tot = 0, done_tot = 0, motor_tot = 0, bm_err = 0;

  always @(negedge clk) if (rst_n) begin
    sens_tot  += int'(sensor_on);
    done_tot  += int'(o_done);
    motor_tot += int'(motor_on);
    if (motor_on != o_busy) bm_err++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    sensor_in = 1'b1; cyc(hi);
    sensor_in = 1'b0; cyc(lo);
  endtask

  task automatic run_vec(input vec_t v);
    int s0, d0, m0;
    vec_t e;
    i_m_on = 1'b0; porciones = v.porc; cyc(3);
    s0 = sens_tot; d0 = done_tot; m0 = motor_tot;
    i_m_on = 1'b1; cyc(2);
    porciones = 3'd1;  // must be ignored once the target is latched
    for (int k = 0; k < v.npulse; k++) pulse(v.hi, v.lo);
    if (v.abort) i_m_on = 1'b0;
    cyc(v.tail);
    exp_q.push_back(v);
    e = exp_q.pop_front();
    chk({e.name, ".count"}, int'(o_count), e.exp_count);
    chk({e.name, ".sensor_on"}, sens_tot - s0, e.exp_sens);
    chk({e.name, ".done"}, done_tot - d0, e.exp_done);
    chk({e.name, ".fault"}, int'(o_fault), e.exp_fault);
    chk({e.name, ".motor_end"}, int'(motor_on), 0);
    chk({e.name, ".motor_ran"}, int'((motor_tot - m0) > 0), int'(e.porc != 3'd0));
  endtask

  initial begin
    vec_t v;
    int s0, d0;
    vecs[0] = '{"normal3",  3'd3, 3, 10, 10, 1'b0, 5,  3, 3, 1, 0};
    vecs[1] = '{"one",      3'd1, 1, 6,  10, 1'b0, 5,  1, 1, 1, 0};
    vecs[2] = '{"seven",    3'd7, 7, 6,  6,  1'b0, 5,  7, 7, 1, 0};
    vecs[3] = '{"abort",    3'd5, 2, 10, 10, 1'b1, 3,  2, 2, 0, 0};
    vecs[4] = '{"zero",     3'd0, 0, 0,  0,  1'b0, 5,  2, 0, 0, 0};
    vecs[5] = '{"timeout",  3'd2, 1, 10, 10, 1'b0, 70, 1, 1, 0, 1};

    #2;
    chk("rst.motor", int'(motor_on), 0);
    chk("rst.busy",  int'(o_busy), 0);
    chk("rst.count", int'(o_count), 0);
    chk("rst.done",  int'(o_done), 0);
    chk("rst.fault", int'(o_fault), 0);
    chk("rst.sensor_on", int'(sensor_on), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Faulted: a new request edge must not restart anything.
    i_m_on = 1'b0; porciones = 3'd2; cyc(2);
    i_m_on = 1'b1; cyc(4);
    chk("fault.sticky", int'(o_fault), 1);
    chk("fault.busy",   int'(o_busy), 0);
    chk("fault.count",  int'(o_count), 1);
    i_clear = 1'b1; cyc(1);
    i_clear = 1'b0; cyc(1);
    chk("fault.cleared", int'(o_fault), 0);
    v = '{"recover", 3'd2, 2, 10, 10, 1'b0, 5, 2, 2, 1, 0};
    run_vec(v);

    // Glitches shorter than the debounce window are not portions.
    i_m_on = 1'b0; porciones = 3'd2; cyc(2);
    s0 = sens_tot; d0 = done_tot;
    i_m_on = 1'b1; cyc(2);
    pulse(1, 5); pulse(2, 5); pulse(3, 5);
    chk("glitch.count", int'(o_count), 0);
    chk("glitch.sensor_on", sens_tot - s0, 0);
    chk("glitch.busy", int'(o_busy), 1);
    pulse(6, 6);
    chk("glitch.six_count", int'(o_count), 1);
    chk("glitch.six_sensor_on", sens_tot - s0, 1);
    pulse(10, 10);
    chk("glitch.done", done_tot - d0, 1);
    chk("glitch.final_count", int'(o_count), 2);

    // Asynchronous reset in the middle of a run.
    i_m_on = 1'b0; porciones = 3'd3; cyc(2);
    i_m_on = 1'b1; cyc(2);
    pulse(10, 5);
    chk("midrst.busy_before", int'(o_busy), 1);
    chk("midrst.count_before", int'(o_count), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.motor_async", int'(motor_on), 0);
    chk("midrst.count_async", int'(o_count), 0);
    chk("midrst.busy_async",  int'(o_busy), 0);
    cyc(2);
    @(negedge clk); #2;
    rst_n = 1'b1;
    cyc(6);
    chk("midrst.no_start_busy",  int'(o_busy), 0);
    chk("midrst.no_start_motor", int'(motor_on), 0);
    v = '{"post_rst", 3'd1, 1, 10, 10, 1'b0, 5, 1, 1, 1, 0};
    run_vec(v);

    chk("motor_eq_busy", bm_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dispenser_ctrl.md
DISPENSER_CTRL -- requirements
Module: dispenser_ctrl

Interface
REQ-001 Parameter CLOCK_FREQ, 32'd50_000_000, clk cycles per second; sets the 1-s tick used by the timeout.
REQ-002 Parameter DEBOUNCE_CYCLES, 16'd50_000, consecutive stable cycles required before the filtered sensor level changes.
REQ-003 Parameter TIMEOUT_SEC, 8'd10, whole seconds without a portion event in RUN before a fault.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 i_m_on  input  1  dispense request level from the countdown timer; its rising edge starts a dispense.
REQ-007 porciones  input  3  number of portions to dispense, 0-7.
REQ-008 sensor_in  input  1  raw, asynchronous portion-drop sensor; high while a portion passes.
REQ-009 i_clear  input  1  synchronous clear of the FAULT state.
REQ-010 motor_on  output  1  motor drive, high only in RUN.
REQ-011 sensor_on  output  1  one-cycle pulse per accepted portion event.
REQ-012 o_count  output  3  portions counted in the current or most recent dispense.
REQ-013 o_busy  output  1  high in RUN.
REQ-014 o_done  output  1  one-cycle pulse on successful completion.
REQ-015 o_fault  output  1  high in FAULT.

Function
REQ-016 sensor_in passes through a 2-FF synchronizer before any other use.
REQ-017 Filtered level: changes to the synchronized value only after the synchronized value has differed from the filtered level for DEBOUNCE_CYCLES consecutive cycles.
REQ-018 Debounce counter: clears whenever the synchronized value equals the filtered level.
REQ-019 Portion event: a 0->1 transition of the filtered level; it is accepted only in RUN.
REQ-020 Request edge: i_m_on is registered once; the request edge is i_m_on=1 while the registered copy=0.
REQ-021 FSM states: IDLE, RUN, DONE, FAULT.
REQ-022 IDLE, request edge with porciones!=0: latch target=porciones, clear o_count, clear timeout counters, go to RUN next cycle.
REQ-023 IDLE, request edge with porciones==0: ignored; stay in IDLE, no outputs change.
REQ-024 RUN, accepted portion event: o_count increments by 1, sensor_on=1 for exactly that cycle, and the seconds-without-event counter clears.
REQ-025 RUN, accepted event that makes o_count equal target: go to DONE.
REQ-026 DONE: lasts exactly one cycle with o_done=1, then goes to IDLE.
REQ-027 RUN timeout: a 1-s tick is generated every CLOCK_FREQ cycles, counting only in RUN.
REQ-028 RUN timeout: when the seconds-without-event counter reaches TIMEOUT_SEC, go to FAULT.
REQ-029 RUN, portion event and timeout in the same cycle: the event wins, and the seconds counter clears.
REQ-030 RUN, i_m_on low: abort to IDLE next cycle; motor_on falls, no o_done, o_count holds.
REQ-031 porciones changes during RUN are ignored because target is latched.
REQ-032 FAULT is sticky; it exits to IDLE only on i_clear=1 or reset; request edges in FAULT are ignored.
REQ-033 Output timing: motor_on and o_busy are registered, equal 1 exactly in the cycles the FSM is in RUN, and drop in the cycle after the final event.
REQ-034 o_count saturates at 7 and never wraps.

Reset
REQ-035 rst_n=0 asynchronously forces: FSM=IDLE, motor_on=0, sensor_on=0, o_busy=0, o_done=0, o_fault=0, o_count=0.
REQ-036 rst_n=0 asynchronously forces: synchronizer, filtered level, debounce, tick and seconds counters all to 0.
REQ-037 Reset asserted mid-RUN stops the motor immediately, without waiting for a clock edge.
REQ-038 After reset deasserts, a request edge is required to start a dispense; an i_m_on already high at deassertion does not start one.

Verification (CLOCK_FREQ=20, DEBOUNCE_CYCLES=4, TIMEOUT_SEC=3, clk 10 ns)
REQ-039 Normal dispense: porciones=3, raise i_m_on, then 3 clean sensor pulses 10 cycles high / 10 low -> motor_on high, 3 sensor_on pulses, o_count=3, one o_done pulse, motor_on=0.
REQ-040 Bounce rejection: sensor glitches of 1-3 cycles -> no sensor_on, o_count unchanged; a 6-cycle high pulse -> exactly one event.
REQ-041 Timeout: porciones=2, request, 1 pulse, then no sensor for >60 cycles -> o_fault=1, motor_on=0, o_count=1.
REQ-042 Fault recovery: while faulted, a request edge -> no effect; i_clear -> IDLE, after which a new request runs normally.
REQ-043 Zero portions and abort: porciones=0 request -> stays IDLE; porciones=5 request then i_m_on low after 2 events -> IDLE, o_count=2, no o_done.
REQ-044 Reset mid-RUN: rst_n=0 during RUN -> motor_on=0 asynchronously, o_count=0; i_m_on held high across reset release -> stays IDLE.
